// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory sequencer: FSM state encoding and port indices.
// Ports: none (package).
// Imported by mem_arbiter and rr_arbiter2.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic PORT_PROC = 1'b0;
   localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way round-robin pick between processor and loader.
// Ports: req_p/req_l requests, last = port served most recently;
//        win = winning port index, valid = at least one request present.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic req_p,
   input  logic req_l,
   input  logic last,
   output logic win,
   output logic valid
);

   always_comb begin
      valid = req_p | req_l;
      win   = PORT_PROC;
      if (req_p && req_l) begin
         // Tie: the port that was not served last goes next.
         win = ~last;
      end else if (req_l) begin
         win = PORT_LOAD;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences processor and loader accesses onto a single-port synchronous memory:
// IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> DONE -> IDLE.
// Ports: p_*/l_* request/grant/ack per requester, mem_* to the macro, rdata/busy shared.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_gnt,
   output logic              p_ack,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              arb_win, arb_vld;

   rr_arbiter2 u_rr (
      .req_p (p_req),
      .req_l (l_req),
      .last  (last_q),
      .win   (arb_win),
      .valid (arb_vld)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               owner_d = arb_win;
               last_d  = arb_win;
               we_d    = (arb_win == PORT_LOAD) ? l_we    : p_we;
               addr_d  = (arb_win == PORT_LOAD) ? l_addr  : p_addr;
               wdata_d = (arb_win == PORT_LOAD) ? l_wdata : p_wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               rdata_d = mem_rdata;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q <= ST_IDLE;
         last_q  <= PORT_LOAD;
         owner_q <= PORT_PROC;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every output comes from registers or the state decode only.
   assign busy      = (state_q != ST_IDLE);
   assign p_gnt     = busy && (owner_q == PORT_PROC);
   assign l_gnt     = busy && (owner_q == PORT_LOAD);
   assign p_ack     = (state_q == ST_DONE) && (owner_q == PORT_PROC);
   assign l_ack     = (state_q == ST_DONE) && (owner_q == PORT_LOAD);
   assign mem_wren  = (state_q == ST_ISSUE) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), one active at a time.
// Transaction-level reference model: round-robin winner, fixed latencies, word array.
// Directed steps then randomized transactions, checked every cycle of each transaction.
module tb_mem_arbiter;

   localparam int AW = 7;
   localparam int DW = 10;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          resetn;
   logic          p_req, p_we, l_req, l_we;
   logic [AW-1:0] p_addr, l_addr;
   logic [DW-1:0] p_wdata, l_wdata;
   int            sel;

   logic [1:0]    p_req_g, l_req_g;
   logic [1:0]    p_gnt_o, p_ack_o, l_gnt_o, l_ack_o, wren_o, busy_o;
   logic [DW-1:0] rdata_o [2];
   logic [DW-1:0] mem_wdata_o [2];
   logic [DW-1:0] mem_rdata_i [2];
   logic [AW-1:0] mem_addr_o [2];

   assign p_req_g[0] = p_req && (sel == 0);
   assign l_req_g[0] = l_req && (sel == 0);
   assign p_req_g[1] = p_req && (sel == 1);
   assign l_req_g[1] = l_req && (sel == 1);

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .clock(clock), .resetn(resetn),
      .p_req(p_req_g[0]), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt_o[0]), .p_ack(p_ack_o[0]),
      .l_req(l_req_g[0]), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt_o[0]), .l_ack(l_ack_o[0]),
      .rdata(rdata_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
      .mem_wren(wren_o[0]), .mem_rdata(mem_rdata_i[0]), .busy(busy_o[0])
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .clock(clock), .resetn(resetn),
      .p_req(p_req_g[1]), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt_o[1]), .p_ack(p_ack_o[1]),
      .l_req(l_req_g[1]), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt_o[1]), .l_ack(l_ack_o[1]),
      .rdata(rdata_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
      .mem_wren(wren_o[1]), .mem_rdata(mem_rdata_i[1]), .busy(busy_o[1])
   );

   // Memory macros: synchronous write, read data delayed by 1 or 3 cycles.
   logic [DW-1:0] ram  [2][128] = '{default: '0};
   logic [DW-1:0] pipe [2][3]   = '{default: '0};

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (wren_o[i]) ram[i][mem_addr_o[i]] <= mem_wdata_o[i];
         pipe[i][0] <= ram[i][mem_addr_o[i]];
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end
   assign mem_rdata_i[0] = pipe[0][0];
   assign mem_rdata_i[1] = pipe[1][2];

   // Reference model state
   logic [DW-1:0] mdl [2][128] = '{default: '0};
   bit            last_m [2];
   logic [DW-1:0] rdata_m [2];

   int    n_cmp = 0;
   int    n_err = 0;
   string cur = "init";

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur, name, obs, exp);
      end
   endtask

   task automatic chk_quiet(input int s);
      chk("busy",  32'(busy_o[s]),  0);
      chk("p_gnt", 32'(p_gnt_o[s]), 0);
      chk("l_gnt", 32'(l_gnt_o[s]), 0);
      chk("p_ack", 32'(p_ack_o[s]), 0);
      chk("l_ack", 32'(l_ack_o[s]), 0);
      chk("wren",  32'(wren_o[s]),  0);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      resetn = 1'b1;
      p_req  = 1'b0;
      l_req  = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b0;
      for (int s = 0; s < 2; s++) begin
         last_m[s]  = 1'b1;
         rdata_m[s] = '0;
         chk_quiet(s);
         chk("rst_addr",  32'(mem_addr_o[s]),  0);
         chk("rst_wdata", 32'(mem_wdata_o[s]), 0);
         chk("rst_rdata", 32'(rdata_o[s]),     0);
      end
   endtask

   // Starts and ends at the negedge of an IDLE cycle of the selected instance.
   task automatic do_txn(input bit pr, input bit lr, input bit pwe, input bit lwe,
                         input logic [AW-1:0] pa, input logic [AW-1:0] la,
                         input logic [DW-1:0] pd, input logic [DW-1:0] ld,
                         input bit hold, input bit drop_wait);
      bit            w, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            lat;
      w  = (pr && lr) ? ~last_m[sel] : lr;
      last_m[sel] = w;
      we  = w ? lwe : pwe;
      a   = w ? la  : pa;
      d   = w ? ld  : pd;
      lat = we ? 2 : 2 + ((sel == 0) ? 1 : 3);
      chk("start_busy", 32'(busy_o[sel]), 0);
      p_req = pr; p_we = pwe; p_addr = pa; p_wdata = pd;
      l_req = lr; l_we = lwe; l_addr = la; l_wdata = ld;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         if (drop_wait && k == 2) begin
            p_req = 1'b0;
            l_req = 1'b0;
         end
         chk($sformatf("p_gnt@%0d", k), 32'(p_gnt_o[sel]), 32'(!w));
         chk($sformatf("l_gnt@%0d", k), 32'(l_gnt_o[sel]), 32'(w));
         chk($sformatf("p_ack@%0d", k), 32'(p_ack_o[sel]), 32'(k == lat && !w));
         chk($sformatf("l_ack@%0d", k), 32'(l_ack_o[sel]), 32'(k == lat && w));
         chk($sformatf("wren@%0d", k),  32'(wren_o[sel]),  32'(k == 1 && we));
         chk($sformatf("addr@%0d", k),  32'(mem_addr_o[sel]),  32'(a));
         chk($sformatf("wdata@%0d", k), 32'(mem_wdata_o[sel]), 32'(d));
         if (k == lat) begin
            if (!we) rdata_m[sel] = mdl[sel][a];
            chk("rdata", 32'(rdata_o[sel]), 32'(rdata_m[sel]));
         end
      end
      if (we) mdl[sel][a] = d;
      if (!hold) begin
         p_req = 1'b0;
         l_req = 1'b0;
      end
      @(negedge clock);
      chk_quiet(sel);
   endtask

   initial begin
      sel = 0;
      p_req = 0; l_req = 0; p_we = 0; l_we = 0;
      p_addr = '0; l_addr = '0; p_wdata = '0; l_wdata = '0;
      resetn = 1'b1;

      cur = "reset";
      apply_reset();

      cur = "p_write";
      do_txn(1, 0, 1, 0, 7'd5, 7'd0, 10'h2A3, 10'h000, 0, 0);

      cur = "l_wr_rd_lat1";
      do_txn(0, 1, 0, 1, 7'd0, 7'd7, 10'h000, 10'h155, 0, 0);
      do_txn(0, 1, 0, 0, 7'd0, 7'd7, 10'h000, 10'h000, 0, 0);

      cur = "l_wr_rd_lat3";
      sel = 1;
      do_txn(0, 1, 0, 1, 7'd0, 7'd7, 10'h000, 10'h155, 0, 0);
      do_txn(0, 1, 0, 0, 7'd0, 7'd7, 10'h000, 10'h000, 0, 0);

      cur = "tie_alternate";
      sel = 0;
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         do_txn(1, 1, 1'($urandom()), 1'($urandom()),
                AW'($urandom_range(31, 16)), AW'($urandom_range(31, 16)),
                DW'($urandom()), DW'($urandom()), n != 3, 0);
      end

      cur = "drop_in_wait";
      do_txn(1, 0, 0, 0, 7'd7, 7'd0, 10'h000, 10'h000, 0, 1);
      @(negedge clock);
      chk_quiet(0);

      cur = "reset_in_wait";
      p_req = 1; p_we = 0; p_addr = 7'd7; l_req = 0;
      @(negedge clock);
      chk("issue_gnt", 32'(p_gnt_o[0]), 1);
      @(negedge clock);
      chk("wait_busy", 32'(busy_o[0]), 1);
      p_req  = 0;
      resetn = 1'b1;
      @(negedge clock);
      resetn = 1'b0;
      last_m[0]  = 1'b1;
      rdata_m[0] = '0;
      chk_quiet(0);
      chk("rdata", 32'(rdata_o[0]), 0);
      @(negedge clock);
      chk_quiet(0);
      cur = "tie_after_reset";
      do_txn(1, 1, 0, 1, 7'd7, 7'd9, 10'h000, 10'h0F0, 0, 0);

      cur = "random";
      for (int n = 0; n < 60; n++) begin
         bit pr, lr;
         sel = int'($urandom_range(1, 0));
         pr  = 1'($urandom());
         lr  = pr ? 1'($urandom()) : 1'b1;
         do_txn(pr, lr, 1'($urandom()), 1'($urandom()),
                AW'($urandom_range(15, 0)), AW'($urandom_range(15, 0)),
                DW'($urandom()), DW'($urandom()), 1'($urandom()), 0);
      end
      p_req = 0;
      l_req = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
